// File: rtl/hba_qtr_array_if.sv
//------------------------------------------------------------------------------
// hba_qtr_array_if
// HBA bus signal bundle for one slave peripheral.
//   hba_rnw           master -> slave  1 = read, 0 = write
//   hba_select        master -> slave  transfer in progress
//   hba_abus          master -> slave  {peripheral select, register offset}
//   hba_dbus          master -> slave  write data
//   hba_dbus_slave    slave  -> master read data, 0 when not acking
//   hba_xferack_slave slave  -> master one-cycle transfer acknowledge
//------------------------------------------------------------------------------
`timescale 1ns/1ps
interface hba_qtr_array_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DBUS_WIDTH = 8
);
    logic                  hba_rnw;
    logic                  hba_select;
    logic [ADDR_WIDTH-1:0] hba_abus;
    logic [DBUS_WIDTH-1:0] hba_dbus;
    logic [DBUS_WIDTH-1:0] hba_dbus_slave;
    logic                  hba_xferack_slave;

    modport master (
        output hba_rnw, hba_select, hba_abus, hba_dbus,
        input  hba_dbus_slave, hba_xferack_slave
    );

    modport slave (
        input  hba_rnw, hba_select, hba_abus, hba_dbus,
        output hba_dbus_slave, hba_xferack_slave
    );
endinterface

// File: rtl/hba_qtr_array.sv
//------------------------------------------------------------------------------
// hba_qtr_array
// Reads NUM_CH Pololu QTR reflectance sensors in parallel. A shared
// charge/measure FSM drives all sensor nodes high, releases them, and counts
// per channel how many 10 us ticks each node stays high (saturating at 255).
// Results are exposed on the HBA bus with a hysteresis side bitmask, a
// period/threshold interrupt and an estop pulse towards hba_motor.
//
// Ports:
//   hba_clk, hba_reset   clock, synchronous active-high reset
//   bus                  HBA slave interface (hba_qtr_array_if.slave)
//   slave_interrupt      one-cycle interrupt pulse
//   slave_estop          one-cycle estop pulse
//   qtr_out_en/out_sig   per-channel node driver enable / value
//   qtr_in_sig           per-channel node level
//   qtr_ctrl             per-channel emitter LED enable
//
// Registers: 0 CTRL {emit_on,estop_en,intr_type,intr_en,enable}, 1 PERIOD,
//   2 THRESH, 3 HYST, 4 SIDE (RO), 5.. VALUE[i] (RO).
//
// Optional macro HBA_QTR_AVG_EN: VALUE[i] becomes a running two-sample
// average, (VALUE + count + 1) >> 1; the first sample after reset or after
// enable rises loads the raw count.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module hba_qtr_array #(
    parameter int CLK_FREQUENCY     = 60_000_000,
    parameter int NUM_CH            = 4,
    parameter int DBUS_WIDTH        = 8,
    parameter int PERIPH_ADDR_WIDTH = 4,
    parameter int REG_ADDR_WIDTH    = 8,
    parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
    parameter int PERIPH_ADDR       = 0,
    parameter int CHARGE_TICKS      = 1
) (
    input  logic                hba_clk,
    input  logic                hba_reset,
    hba_qtr_array_if.slave      bus,
    output logic                slave_interrupt,
    output logic                slave_estop,
    output logic [NUM_CH-1:0]   qtr_out_en,
    output logic [NUM_CH-1:0]   qtr_out_sig,
    input  logic [NUM_CH-1:0]   qtr_in_sig,
    output logic [NUM_CH-1:0]   qtr_ctrl
);

    localparam int TICK10 = (CLK_FREQUENCY / 100_000 > 0) ? CLK_FREQUENCY / 100_000 : 1;
    localparam int TICK50 = (CLK_FREQUENCY / 20 > 0) ? CLK_FREQUENCY / 20 : 1;
    localparam int P10_W  = $clog2(TICK10 + 1);
    localparam int P50_W  = $clog2(TICK50 + 1);

    typedef enum logic [1:0] {S_IDLE, S_CHARGE, S_MEASURE, S_DONE} state_t;

    // Threshold band edges, saturated to the 8-bit value range.
    function automatic logic [7:0] f_hi(input logic [7:0] t, input logic [7:0] h);
        logic [8:0] s;
        s = {1'b0, t} + {1'b0, h};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    function automatic logic [7:0] f_lo(input logic [7:0] t, input logic [7:0] h);
        logic signed [9:0] d;
        d = $signed({2'b00, t}) - $signed({2'b00, h});
        return (d < 0) ? 8'h00 : 8'(d);
    endfunction

`ifdef HBA_QTR_AVG_EN
    function automatic logic [7:0] f_avg(input logic [7:0] v, input logic [7:0] c);
        logic [8:0] s;
        s = {1'b0, v} + {1'b0, c} + 9'd1;
        return 8'(s >> 1);
    endfunction
`endif

    // Register file
    logic [4:0]        r_ctrl;
    logic [7:0]        r_period;
    logic [7:0]        r_thresh;
    logic [7:0]        r_hyst;
    logic [NUM_CH-1:0] r_side;
    logic [7:0]        r_value [NUM_CH];

    // Bus side
    logic                  r_ack;
    logic                  r_held;
    logic [DBUS_WIDTH-1:0] r_rdata;
    logic                  w_match;
    logic                  w_access;
    logic                  w_wr;
    logic [REG_ADDR_WIDTH-1:0] w_off;
    logic [DBUS_WIDTH-1:0] w_rdata;

    // Sample timing
    logic [P50_W-1:0] r_pre50;
    logic [7:0]       r_pcnt;
    logic             w_tick50;
    logic             w_sync;

    // Measure FSM
    state_t            r_state;
    state_t            w_state_nxt;
    logic [P10_W-1:0]  r_pre10;
    logic              w_tick10;
    logic [7:0]        r_chg;
    logic [7:0]        r_count [NUM_CH];
    logic [NUM_CH-1:0] r_frozen;
    logic              w_all_done;

    // DONE evaluation
    logic [7:0]        w_new [NUM_CH];
    logic [NUM_CH-1:0] w_side_nxt;
    logic              w_any255;
    logic              r_intr;
    logic              r_estop;

    //--------------------------------------------------------------------------
    // Bus decode: one ack per select; r_held blocks re-acks while the master
    // keeps select asserted after the ack cycle.
    //--------------------------------------------------------------------------
    assign w_match  = bus.hba_select &&
                      (bus.hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH] == PERIPH_ADDR_WIDTH'(PERIPH_ADDR));
    assign w_access = w_match && !r_ack && !r_held;
    assign w_wr     = w_access && !bus.hba_rnw;
    assign w_off    = bus.hba_abus[REG_ADDR_WIDTH-1:0];

    always_comb begin
        w_rdata = '0;
        if (w_off == REG_ADDR_WIDTH'(0)) begin
            w_rdata = {3'b000, r_ctrl};
        end else if (w_off == REG_ADDR_WIDTH'(1)) begin
            w_rdata = r_period;
        end else if (w_off == REG_ADDR_WIDTH'(2)) begin
            w_rdata = r_thresh;
        end else if (w_off == REG_ADDR_WIDTH'(3)) begin
            w_rdata = r_hyst;
        end else if (w_off == REG_ADDR_WIDTH'(4)) begin
            for (int i = 0; i < NUM_CH; i++) w_rdata[i] = r_side[i];
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_off == REG_ADDR_WIDTH'(5 + i)) w_rdata = r_value[i];
            end
        end
    end

    always_ff @(posedge hba_clk) begin
        if (hba_reset) begin
            r_ack    <= 1'b0;
            r_held   <= 1'b0;
            r_rdata  <= '0;
            r_ctrl   <= '0;
            r_period <= '0;
            r_thresh <= '0;
            r_hyst   <= '0;
        end else begin
            r_ack   <= w_access;
            r_held  <= bus.hba_select && (r_ack || r_held);
            r_rdata <= (w_access && bus.hba_rnw) ? w_rdata : '0;
            if (w_wr) begin
                if (w_off == REG_ADDR_WIDTH'(0))      r_ctrl   <= bus.hba_dbus[4:0];
                else if (w_off == REG_ADDR_WIDTH'(1)) r_period <= bus.hba_dbus;
                else if (w_off == REG_ADDR_WIDTH'(2)) r_thresh <= bus.hba_dbus;
                else if (w_off == REG_ADDR_WIDTH'(3)) r_hyst   <= bus.hba_dbus;
            end
        end
    end

    assign bus.hba_dbus_slave    = r_rdata;
    assign bus.hba_xferack_slave = r_ack;

    //--------------------------------------------------------------------------
    // Sample timing. PERIOD is only compared at 50 ms boundaries, so a write
    // takes effect at the next boundary; if the counter is already past the
    // new value it runs on through 255 and wraps.
    //--------------------------------------------------------------------------
    assign w_tick50 = (r_pre50 == P50_W'(TICK50 - 1));
    assign w_sync   = w_tick50 && (r_pcnt == r_period);

    always_ff @(posedge hba_clk) begin
        if (hba_reset) begin
            r_pre50 <= '0;
            r_pcnt  <= '0;
        end else begin
            r_pre50 <= w_tick50 ? '0 : r_pre50 + 1'b1;
            if (w_tick50) r_pcnt <= (r_pcnt == r_period) ? 8'd0 : r_pcnt + 8'd1;
        end
    end

    //--------------------------------------------------------------------------
    // Measure FSM
    //--------------------------------------------------------------------------
    assign w_tick10 = (r_pre10 == P10_W'(TICK10 - 1));

    always_comb begin
        w_all_done = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!r_frozen[i] && (r_count[i] != 8'hFF)) w_all_done = 1'b0;
        end
    end

    always_ff @(posedge hba_clk) begin
        if (hba_reset) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        qtr_out_en  = '0;
        qtr_out_sig = '0;
        qtr_ctrl    = r_ctrl[4] ? '1 : '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_sync && r_ctrl[0]) w_state_nxt = S_CHARGE;
            end
            S_CHARGE: begin
                qtr_out_en  = '1;
                qtr_out_sig = '1;
                qtr_ctrl    = '1;
                if (w_tick10 && (r_chg == 8'(CHARGE_TICKS - 1))) w_state_nxt = S_MEASURE;
            end
            S_MEASURE: begin
                qtr_ctrl = '1;
                if (w_all_done) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                qtr_ctrl    = '1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // 10 us prescaler and charge tick counter restart on every state entry.
    always_ff @(posedge hba_clk) begin
        if (hba_reset || (w_state_nxt != r_state)) begin
            r_pre10 <= '0;
            r_chg   <= '0;
        end else begin
            r_pre10 <= w_tick10 ? '0 : r_pre10 + 1'b1;
            if ((r_state == S_CHARGE) && w_tick10) r_chg <= r_chg + 8'd1;
        end
    end

    // A channel counts while its node is still high; the first low reading
    // freezes it for the rest of the measurement.
    always_ff @(posedge hba_clk) begin
        if (hba_reset || (r_state == S_DONE)) begin
            r_frozen <= '0;
            for (int i = 0; i < NUM_CH; i++) r_count[i] <= '0;
        end else if ((r_state == S_MEASURE) && w_tick10) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!r_frozen[i] && (r_count[i] != 8'hFF)) begin
                    if (qtr_in_sig[i]) r_count[i] <= r_count[i] + 8'd1;
                    else               r_frozen[i] <= 1'b1;
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // DONE: latch values, update side bits, raise interrupt/estop.
    //--------------------------------------------------------------------------
`ifdef HBA_QTR_AVG_EN
    logic r_first;

    always_ff @(posedge hba_clk) begin
        if (hba_reset) begin
            r_first <= 1'b1;
        end else if (w_wr && (w_off == REG_ADDR_WIDTH'(0)) && bus.hba_dbus[0] && !r_ctrl[0]) begin
            r_first <= 1'b1;
        end else if (r_state == S_DONE) begin
            r_first <= 1'b0;
        end
    end
`endif

    always_comb begin
        w_side_nxt = r_side;
        w_any255   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
`ifdef HBA_QTR_AVG_EN
            w_new[i] = r_first ? r_count[i] : f_avg(r_value[i], r_count[i]);
`else
            w_new[i] = r_count[i];
`endif
            if (w_new[i] > f_hi(r_thresh, r_hyst))      w_side_nxt[i] = 1'b1;
            else if (w_new[i] < f_lo(r_thresh, r_hyst)) w_side_nxt[i] = 1'b0;
            if (w_new[i] == 8'hFF) w_any255 = 1'b1;
        end
    end

    always_ff @(posedge hba_clk) begin
        if (hba_reset) begin
            r_side  <= '0;
            r_intr  <= 1'b0;
            r_estop <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) r_value[i] <= '0;
        end else begin
            r_intr  <= 1'b0;
            r_estop <= 1'b0;
            if (r_state == S_DONE) begin
                r_side  <= w_side_nxt;
                r_intr  <= r_ctrl[1] && (!r_ctrl[2] || (w_side_nxt != r_side));
                r_estop <= r_ctrl[3] && r_ctrl[2] && w_any255;
                for (int i = 0; i < NUM_CH; i++) r_value[i] <= w_new[i];
            end
        end
    end

    assign slave_interrupt = r_intr;
    assign slave_estop     = r_estop;

endmodule
